// File: rtl/pixel_norm_stream.sv
// pixel_norm_stream: per-channel pixel normalisation on an interleaved stream.
// Each raw unsigned sample is rescaled to Q.FRAC in [0,1], its channel mean is
// subtracted, and the result is multiplied by the channel inverse-std. The
// output is a rounded, saturated signed fixed-point value. The datapath is a
// two-stage valid/ready pipeline with a global stall enable.
module pixel_norm_stream #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 16,
  parameter int FRAC  = 8,
  parameter int CH    = 3,
  localparam int CW   = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [IN_W-1:0]  s_data,
  input  logic             s_sof,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [OUT_W-1:0] m_data,
  output logic [CW-1:0]    m_ch,
  input  logic             cfg_we,
  input  logic [CW-1:0]    cfg_ch,
  input  logic [OUT_W-1:0] cfg_mean,
  input  logic [OUT_W-1:0] cfg_istd,
  output logic [15:0]      sat_count
);

  // Scale factor K = round(2^(FRAC+IN_W) / (2^IN_W - 1)), so that full-scale
  // input maps to exactly 1.0 in Q.FRAC.
  localparam logic [63:0] K_DEN = (64'd1 << IN_W) - 64'd1;
  localparam logic [63:0] K_NUM = 64'd1 << (FRAC + IN_W);
  localparam logic [63:0] K_R   = (64'd2 * K_NUM + K_DEN) / (64'd2 * K_DEN);

  // Datapath widths.
  localparam int KW  = FRAC + 2;        // K is slightly above 2^FRAC
  localparam int X_W = FRAC + 2;        // scaled sample, max 2^FRAC
  localparam int P_W = IN_W + KW + 1;   // s_data*K plus rounding term
  localparam int C_W = OUT_W + 2;       // centred value x - mean
  localparam int Y_W = 2 * OUT_W + 3;   // full-width product plus rounding

  localparam logic [P_W-1:0]        K_V     = K_R[P_W-1:0];
  localparam logic [P_W-1:0]        X_HALF  = P_W'(1) << (IN_W - 1);
  localparam logic signed [Y_W-1:0] Y_ROUND = Y_W'(1) << (FRAC - 1);
  localparam logic signed [Y_W-1:0] Y_MAX   = {{(Y_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [Y_W-1:0] Y_MIN   = {{(Y_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
  localparam logic [OUT_W-1:0]      OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0]      OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};
  localparam logic [OUT_W-1:0]      ISTD_ID = OUT_W'(1) << FRAC;

  // Coefficient tables, one entry per channel.
  logic [OUT_W-1:0] mean_r [CH];
  logic [OUT_W-1:0] istd_r [CH];

  // Handshake and channel tracking.
  logic          en;
  logic          accept;
  logic [CW-1:0] ch_cnt;
  logic [CW-1:0] ch_cur;
  logic [CW-1:0] ch_next;

  // Stage-1 (scale and centre) signals.
  logic [P_W-1:0]        xprod;
  logic [X_W-1:0]        x_new;
  logic [OUT_W-1:0]      mean_sel;
  logic [OUT_W-1:0]      istd_sel;
  logic signed [C_W-1:0] c_new;
  logic                  v1;
  logic [CW-1:0]         ch1;
  logic signed [C_W-1:0] c1;
  logic [OUT_W-1:0]      istd1;

  // Stage-2 (multiply, round, clamp) signals.
  logic signed [Y_W-1:0] c_ext;
  logic signed [Y_W-1:0] i_ext;
  logic signed [Y_W-1:0] prod;
  logic signed [Y_W-1:0] y;
  logic                  clamp_hi;
  logic                  clamp_lo;
  logic [OUT_W-1:0]      y_clamp;

  // Whole pipeline advances together; readiness never looks at s_valid.
  assign en      = !m_valid || m_ready;
  assign s_ready = en;
  assign accept  = s_valid && en;

  // Start of frame forces channel 0; otherwise continue the interleave.
  assign ch_cur  = s_sof ? '0 : ch_cnt;
  assign ch_next = (ch_cur == CW'(CH - 1)) ? '0 : ch_cur + CW'(1);

  // Coefficients for the incoming beat are read before any same-cycle write
  // lands, so a write only affects beats accepted after it.
  assign mean_sel = mean_r[ch_cur];
  assign istd_sel = istd_r[ch_cur];

  // Rescale the raw sample into Q.FRAC and subtract the channel mean.
  always_comb begin
    xprod = P_W'(s_data) * K_V + X_HALF;
    x_new = X_W'(xprod >> IN_W);
    c_new = $signed(C_W'(x_new)) - $signed({{2{mean_sel[OUT_W-1]}}, mean_sel});
  end

  // Multiply by inverse-std at full width, round, then clamp to OUT_W.
  always_comb begin
    c_ext    = $signed({{(Y_W-C_W){c1[C_W-1]}}, c1});
    i_ext    = $signed({{(Y_W-OUT_W){1'b0}}, istd1});
    prod     = c_ext * i_ext;
    y        = (prod + Y_ROUND) >>> FRAC;
    clamp_hi = (y > Y_MAX);
    clamp_lo = (y < Y_MIN);
    if (clamp_hi) begin
      y_clamp = OUT_MAX;
    end else if (clamp_lo) begin
      y_clamp = OUT_MIN;
    end else begin
      y_clamp = y[OUT_W-1:0];
    end
  end

  // Coefficient storage; out-of-range channel writes are dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < unsigned'(CH); i++) begin
        mean_r[i] <= '0;
        istd_r[i] <= ISTD_ID;
      end
    end else if (cfg_we && (int'(cfg_ch) < CH)) begin
      mean_r[cfg_ch] <= cfg_mean;
      istd_r[cfg_ch] <= cfg_istd;
    end
  end

  // Stage 1 and the channel counter: capture accepted beats when enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1     <= 1'b0;
      ch1    <= '0;
      c1     <= '0;
      istd1  <= '0;
      ch_cnt <= '0;
    end else if (en) begin
      v1 <= s_valid;
      if (accept) begin
        ch1    <= ch_cur;
        c1     <= c_new;
        istd1  <= istd_sel;
        ch_cnt <= ch_next;
      end
    end
  end

  // Stage 2: output register, held stable while downstream stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_ch    <= '0;
    end else if (en) begin
      m_valid <= v1;
      if (v1) begin
        m_data <= y_clamp;
        m_ch   <= ch1;
      end
    end
  end

  // Count clamp events as beats enter stage 2, sticking at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_count <= '0;
    end else if (en && v1 && (clamp_hi || clamp_lo) && (sat_count != '1)) begin
      sat_count <= sat_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_pixel_norm_stream.sv
// Directed testbench for pixel_norm_stream at default parameters.
module tb_pixel_norm_stream;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_valid;
  logic        s_ready;
  logic [7:0]  s_data;
  logic        s_sof;
  logic        m_valid;
  logic        m_ready;
  logic [15:0] m_data;
  logic [1:0]  m_ch;
  logic        cfg_we;
  logic [1:0]  cfg_ch;
  logic [15:0] cfg_mean;
  logic [15:0] cfg_istd;
  logic [15:0] sat_count;

  int checks   = 0;
  int failures = 0;

  logic [7:0]  in_data  [16];
  logic        in_sof   [16];
  logic [15:0] out_data [16];
  logic [1:0]  out_ch   [16];
  int          n_out;

  always #5 clk = ~clk;

  pixel_norm_stream #(.IN_W(8), .OUT_W(16), .FRAC(8), .CH(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_sof(s_sof),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_ch(m_ch),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_mean(cfg_mean), .cfg_istd(cfg_istd),
    .sat_count(sat_count)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One-cycle coefficient write.
  task automatic cfg_write(input logic [1:0] ch, input logic [15:0] mean, input logic [15:0] istd);
    @(posedge clk); #1;
    cfg_we = 1'b1; cfg_ch = ch; cfg_mean = mean; cfg_istd = istd;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  // Drive n beats from in_data/in_sof with m_ready high, capture outputs.
  task automatic run_stream(input int n, input int max_cycles);
    int   idx;
    int   cyc;
    logic acc;
    idx = 0; cyc = 0; n_out = 0;
    @(posedge clk); #1;
    m_ready = 1'b1;
    s_valid = 1'b1; s_data = in_data[0]; s_sof = in_sof[0];
    while ((idx < n || n_out < n) && cyc < max_cycles) begin
      @(negedge clk);
      acc = s_valid && s_ready;
      if (m_valid && m_ready && n_out < 16) begin
        out_data[n_out] = m_data;
        out_ch[n_out]   = m_ch;
        n_out++;
      end
      @(posedge clk); cyc++;
      #1;
      if (acc) idx++;
      if (idx < n) begin
        s_valid = 1'b1; s_data = in_data[idx]; s_sof = in_sof[idx];
      end else begin
        s_valid = 1'b0; s_sof = 1'b0;
      end
    end
    s_valid = 1'b0; s_sof = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL reset_m_valid got=%b exp=0", m_valid); end
    checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL reset_s_ready got=%b exp=1", s_ready); end
    checks++; if (sat_count !== 16'h0000) begin failures++; $display("FAIL reset_sat got=%h exp=0000", sat_count); end
    checks++; if (m_data !== 16'h0000) begin failures++; $display("FAIL reset_m_data got=%h exp=0000", m_data); end
    checks++; if (m_ch !== 2'd0) begin failures++; $display("FAIL reset_m_ch got=%0d exp=0", m_ch); end
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL post_reset_m_valid got=%b exp=0", m_valid); end
  endtask

  // Identity scaling with exact two-cycle latency.
  task automatic test_scaling();
    logic [7:0]  d   [5] = '{8'd0, 8'd64, 8'd127, 8'd192, 8'd255};
    logic [15:0] e   [5] = '{16'h0000, 16'h0040, 16'h007F, 16'h00C1, 16'h0100};
    logic [1:0]  ec  [5] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1};
    m_ready = 1'b1;
    for (int j = 0; j < 7; j++) begin
      @(posedge clk); #1;
      if (j < 5) begin
        s_valid = 1'b1; s_data = d[j]; s_sof = (j == 0);
      end else begin
        s_valid = 1'b0; s_sof = 1'b0;
      end
      @(negedge clk);
      if (j >= 2) begin
        checks++; if (m_valid !== 1'b1) begin failures++; $display("FAIL scale_valid[%0d] got=%b exp=1", j - 2, m_valid); end
        checks++; if (m_data !== e[j-2]) begin failures++; $display("FAIL scale_data[%0d] got=%h exp=%h", j - 2, m_data, e[j-2]); end
        checks++; if (m_ch !== ec[j-2]) begin failures++; $display("FAIL scale_ch[%0d] got=%0d exp=%0d", j - 2, m_ch, ec[j-2]); end
      end else begin
        checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL scale_latency[%0d] got=%b exp=0", j, m_valid); end
      end
    end
  endtask

  // Non-zero mean and istd on channel 0 only.
  task automatic test_cfg_mean();
    logic [15:0] e  [4] = '{16'hFF00, 16'h0100, 16'h0000, 16'h0100};
    logic [1:0]  ec [4] = '{2'd0, 2'd1, 2'd2, 2'd0};
    cfg_write(2'd0, 16'h0080, 16'h0200);
    in_data[0] = 8'd0;   in_sof[0] = 1'b1;
    in_data[1] = 8'd255; in_sof[1] = 1'b0;
    in_data[2] = 8'd0;   in_sof[2] = 1'b0;
    in_data[3] = 8'd255; in_sof[3] = 1'b0;
    run_stream(4, 40);
    checks++; if (n_out !== 4) begin failures++; $display("FAIL cfg_mean_count got=%0d exp=4", n_out); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (out_data[i] !== e[i]) begin failures++; $display("FAIL cfg_mean_data[%0d] got=%h exp=%h", i, out_data[i], e[i]); end
      checks++; if (out_ch[i] !== ec[i]) begin failures++; $display("FAIL cfg_mean_ch[%0d] got=%0d exp=%0d", i, out_ch[i], ec[i]); end
    end
    cfg_write(2'd0, 16'h0000, 16'h0100);
  endtask

  // Write coinciding with an accepted sof beat: that beat sees old values.
  task automatic test_cfg_timing();
    @(posedge clk); #1;
    m_ready = 1'b1;
    s_valid = 1'b1; s_sof = 1'b1; s_data = 8'd255;
    cfg_we = 1'b1; cfg_ch = 2'd0; cfg_mean = 16'h0000; cfg_istd = 16'h0200;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    @(posedge clk); #1;
    s_valid = 1'b0; s_sof = 1'b0;
    @(negedge clk);
    checks++; if (m_valid !== 1'b1 || m_data !== 16'h0100) begin failures++; $display("FAIL cfg_old_value got=%b/%h exp=1/0100", m_valid, m_data); end
    checks++; if (m_ch !== 2'd0) begin failures++; $display("FAIL cfg_old_ch got=%0d exp=0", m_ch); end
    @(negedge clk);
    checks++; if (m_valid !== 1'b1 || m_data !== 16'h0200) begin failures++; $display("FAIL cfg_new_value got=%b/%h exp=1/0200", m_valid, m_data); end
    checks++; if (m_ch !== 2'd0) begin failures++; $display("FAIL cfg_new_ch got=%0d exp=0", m_ch); end
    cfg_write(2'd0, 16'h0000, 16'h0100);
  endtask

  task automatic test_saturation();
    cfg_write(2'd1, 16'h0000, 16'hFFFF);
    in_data[0] = 8'd0;   in_sof[0] = 1'b1;
    in_data[1] = 8'd255; in_sof[1] = 1'b0;
    run_stream(2, 30);
    checks++; if (n_out !== 2) begin failures++; $display("FAIL sat_hi_count got=%0d exp=2", n_out); end
    checks++; if (out_data[1] !== 16'h7FFF) begin failures++; $display("FAIL sat_hi_data got=%h exp=7FFF", out_data[1]); end
    checks++; if (out_ch[1] !== 2'd1) begin failures++; $display("FAIL sat_hi_ch got=%0d exp=1", out_ch[1]); end
    checks++; if (sat_count !== 16'd1) begin failures++; $display("FAIL sat_count_1 got=%0d exp=1", sat_count); end
    cfg_write(2'd1, 16'h7FFF, 16'hFFFF);
    in_data[0] = 8'd0; in_sof[0] = 1'b1;
    in_data[1] = 8'd0; in_sof[1] = 1'b0;
    run_stream(2, 30);
    checks++; if (out_data[1] !== 16'h8000) begin failures++; $display("FAIL sat_lo_data got=%h exp=8000", out_data[1]); end
    checks++; if (sat_count !== 16'd2) begin failures++; $display("FAIL sat_count_2 got=%0d exp=2", sat_count); end
    cfg_write(2'd1, 16'h0000, 16'h0100);
  endtask

  // Write to a channel index beyond CH-1 must change nothing.
  task automatic test_cfg_ignore();
    cfg_write(2'd3, 16'h0080, 16'h0200);
    for (int i = 0; i < 3; i++) begin
      in_data[i] = 8'd255; in_sof[i] = (i == 0);
    end
    run_stream(3, 30);
    checks++; if (n_out !== 3) begin failures++; $display("FAIL ignore_count got=%0d exp=3", n_out); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (out_data[i] !== 16'h0100) begin failures++; $display("FAIL ignore_data[%0d] got=%h exp=0100", i, out_data[i]); end
    end
    checks++; if (sat_count !== 16'd2) begin failures++; $display("FAIL ignore_sat got=%0d exp=2", sat_count); end
  endtask

  // Continuous input with a 5-cycle downstream stall, then drain.
  task automatic test_back_to_back();
    logic [7:0]  d  [8] = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80};
    logic [15:0] e  [8] = '{16'h000A, 16'h0014, 16'h001E, 16'h0028, 16'h0032, 16'h003C, 16'h0046, 16'h0050};
    logic [1:0]  ec [8] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0, 2'd1};
    int   idx;
    int   cyc;
    logic acc;
    idx = 0; cyc = 0; n_out = 0;
    @(posedge clk); #1;
    m_ready = 1'b0;
    s_valid = 1'b1; s_data = d[0]; s_sof = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      acc = s_valid && s_ready;
      if (m_valid) begin
        checks++; if (m_data !== 16'h000A || m_ch !== 2'd0) begin failures++; $display("FAIL stall_stable[%0d] got=%h/%0d exp=000A/0", c, m_data, m_ch); end
      end
      @(posedge clk); #1;
      if (acc) idx++;
      s_sof = 1'b0; s_data = d[idx];
    end
    checks++; if (idx !== 2) begin failures++; $display("FAIL stall_accepted got=%0d exp=2", idx); end
    checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL stall_s_ready got=%b exp=0", s_ready); end
    m_ready = 1'b1;
    while (n_out < 8 && cyc < 40) begin
      @(negedge clk);
      acc = s_valid && s_ready;
      if (m_valid && m_ready && n_out < 16) begin
        out_data[n_out] = m_data;
        out_ch[n_out]   = m_ch;
        n_out++;
      end
      @(posedge clk); cyc++;
      #1;
      if (acc) idx++;
      if (idx < 8) begin
        s_valid = 1'b1; s_data = d[idx];
      end else begin
        s_valid = 1'b0;
      end
    end
    s_valid = 1'b0;
    checks++; if (n_out !== 8) begin failures++; $display("FAIL b2b_count got=%0d exp=8", n_out); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (out_data[i] !== e[i] || out_ch[i] !== ec[i]) begin failures++; $display("FAIL b2b_beat[%0d] got=%h/%0d exp=%h/%0d", i, out_data[i], out_ch[i], e[i], ec[i]); end
    end
  endtask

  // Reset mid-stream: in-flight beats vanish, coefficients return to identity.
  task automatic test_reset_mid();
    cfg_write(2'd0, 16'h0000, 16'h0200);
    @(posedge clk); #1;
    m_ready = 1'b1;
    s_valid = 1'b1; s_sof = 1'b1; s_data = 8'd255;
    @(posedge clk); #1;
    s_sof = 1'b0;
    @(posedge clk); #1;
    checks++; if (m_valid !== 1'b1 || m_data !== 16'h0200) begin failures++; $display("FAIL pre_reset_beat got=%b/%h exp=1/0200", m_valid, m_data); end
    rst_n = 1'b0; s_valid = 1'b0;
    #1;
    checks++; if (m_valid !== 1'b0) begin failures++; $display("FAIL mid_reset_m_valid got=%b exp=0", m_valid); end
    checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL mid_reset_s_ready got=%b exp=1", s_ready); end
    checks++; if (m_data !== 16'h0000 || m_ch !== 2'd0) begin failures++; $display("FAIL mid_reset_out got=%h/%0d exp=0000/0", m_data, m_ch); end
    checks++; if (sat_count !== 16'd0) begin failures++; $display("FAIL mid_reset_sat got=%0d exp=0", sat_count); end
    @(negedge clk); rst_n = 1'b1;
    in_data[0] = 8'd255; in_sof[0] = 1'b0;
    run_stream(1, 20);
    checks++; if (n_out !== 1) begin failures++; $display("FAIL after_reset_count got=%0d exp=1", n_out); end
    checks++; if (out_data[0] !== 16'h0100) begin failures++; $display("FAIL after_reset_data got=%h exp=0100", out_data[0]); end
    checks++; if (out_ch[0] !== 2'd0) begin failures++; $display("FAIL after_reset_ch got=%0d exp=0", out_ch[0]); end
  endtask

  initial begin
    rst_n = 1'b0; s_valid = 1'b0; s_data = '0; s_sof = 1'b0; m_ready = 1'b1;
    cfg_we = 1'b0; cfg_ch = '0; cfg_mean = '0; cfg_istd = '0;
    test_reset();
    test_scaling();
    test_cfg_mean();
    test_cfg_timing();
    test_saturation();
    test_cfg_ignore();
    test_back_to_back();
    test_reset_mid();
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
